// File: rtl/mem_store_sequencer.sv
// mem_store_sequencer: buffers CPU stores and sequences them onto the data-memory write port
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               store request handshake (ready = buffer not full)
//   in_addr, in_data, in_size       byte address, right-justified value, size (00 W, 01 H, 10 B, 11 illegal)
//   mem_we, mem_addr, mem_wdata,    registered memory write beat: word address, lane data,
//   mem_be, mem_ack                 per-lane byte enables, memory accept strobe
//   busy, err                       activity flag, one-cycle pulse on a dropped illegal entry
module mem_store_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    input  logic [1:0]  in_size,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        busy,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
    state_t state, nstate;
    logic [31:0] addr_q [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [1:0]  size_q [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic push, pop, load0, load1, drop;
    logic [31:0] h_addr, h_data, h_val;
    logic [1:0] h_size;
    logic [7:0] h_mask, lane_mask;
    logic [63:0] wide;
    logic [31:0] b1_addr, b1_data;
    logic [3:0] b1_be;
    logic span_q;
    assign in_ready = count != (AW+1)'(DEPTH);
    assign push = in_valid && in_ready;
    assign busy = (count != '0) || (state != IDLE);
    assign h_addr = addr_q[rd_ptr];
    assign h_data = data_q[rd_ptr];
    assign h_size = size_q[rd_ptr];
    // Left-justify the value so byte k sits in lane k, then shift right by the offset
    // across an 8-lane window: lanes 0..3 form beat 0, lanes 4..7 form beat 1.
    assign h_val = h_size == 2'b00 ? h_data : h_size == 2'b01 ? {h_data[15:0], 16'h0} : {h_data[7:0], 24'h0};
    assign h_mask = h_size == 2'b00 ? 8'b0000_1111 : h_size == 2'b01 ? 8'b0000_0011 : 8'b0000_0001;
    assign lane_mask = h_mask << h_addr[1:0];
    assign wide = {h_val, 32'h0} >> {h_addr[1:0], 3'b000};
    always_comb begin
        nstate = state;
        pop = 1'b0;
        load0 = 1'b0;
        load1 = 1'b0;
        drop = 1'b0;
        case (state)
            IDLE: if (count != '0) begin
                pop = 1'b1;
                drop = h_size == 2'b11;
                load0 = !drop;
                nstate = drop ? IDLE : BEAT0;
            end
            default: if (mem_ack) begin
                if (state == BEAT0 && span_q) begin
                    load1 = 1'b1;
                    nstate = BEAT1;
                end else if (count != '0) begin
                    pop = 1'b1;
                    drop = h_size == 2'b11;
                    load0 = !drop;
                    nstate = drop ? IDLE : BEAT0;
                end else begin
                    nstate = IDLE;
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= in_addr;
            data_q[wr_ptr] <= in_data;
            size_q[wr_ptr] <= in_size;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            mem_be <= '0;
            err <= 1'b0;
            b1_addr <= '0;
            b1_data <= '0;
            b1_be <= '0;
            span_q <= 1'b0;
        end else begin
            state <= nstate;
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            err <= drop;
            if (load0) begin
                mem_we <= 1'b1;
                mem_addr <= {h_addr[31:2], 2'b00};
                mem_wdata <= wide[63:32];
                mem_be <= lane_mask[3:0];
                b1_addr <= {h_addr[31:2] + 30'd1, 2'b00};
                b1_data <= wide[31:0];
                b1_be <= lane_mask[7:4];
                span_q <= |lane_mask[7:4];
            end else if (load1) begin
                mem_addr <= b1_addr;
                mem_wdata <= b1_data;
                mem_be <= b1_be;
                span_q <= 1'b0;
            end else if (nstate == IDLE) begin
                mem_we <= 1'b0;
                mem_wdata <= '0;
                mem_be <= '0;
            end
        end
    end
endmodule
